// File: rtl/nios_system_multi_timer.sv
// nios_system_multi_timer
// -----------------------------------------------------------------------------
// Multi-channel interval timer for the Nios II data bus. NUM_CH independent
// down-counters, each with an 8-bit prescaler, one-shot or continuous mode and
// a snapshot register. A global register reports and clears the pending
// (timed-out and interrupt-enabled) channels. All channel interrupts are ORed
// onto a single irq line.
//
// Register map (word addresses):
//   4c+0  STATUS    read {RUN,TO}; any write clears TO
//   4c+1  CONTROL   bit0 ITO, bit1 CONT, bit2 START, bit3 STOP, [15:8] PRESCALE
//   4c+2  PERIOD    COUNTER_WIDTH bits; a write forces a stopped reload
//   4c+3  SNAPSHOT  any write captures the live counter
//   4*NUM_CH GLOBAL read pending mask; write 1s clear TO bits
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data (one cycle after address)
//   irq         OR of all enabled channel timeouts
// -----------------------------------------------------------------------------
module nios_system_multi_timer #(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int RESET_PERIOD  = 99999,
    parameter int ADDR_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int CH_BITS = ADDR_WIDTH - 2;
    localparam logic [COUNTER_WIDTH-1:0] RESET_CNT   = COUNTER_WIDTH'(RESET_PERIOD);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = COUNTER_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]    GLOBAL_ADDR = ADDR_WIDTH'(4 * NUM_CH);

    // Per-channel state
    logic [COUNTER_WIDTH-1:0] period_q   [NUM_CH];
    logic [COUNTER_WIDTH-1:0] period_d   [NUM_CH];
    logic [COUNTER_WIDTH-1:0] counter_q  [NUM_CH];
    logic [COUNTER_WIDTH-1:0] counter_d  [NUM_CH];
    logic [COUNTER_WIDTH-1:0] snap_q     [NUM_CH];
    logic [COUNTER_WIDTH-1:0] snap_d     [NUM_CH];
    logic [7:0]               prescale_q [NUM_CH];
    logic [7:0]               prescale_d [NUM_CH];
    logic [7:0]               pscCnt_q   [NUM_CH];
    logic [7:0]               pscCnt_d   [NUM_CH];
    logic [NUM_CH-1:0]        run_q, run_d;
    logic [NUM_CH-1:0]        to_q, to_d;
    logic [NUM_CH-1:0]        ito_q, ito_d;
    logic [NUM_CH-1:0]        cont_q, cont_d;
    logic [31:0]              readdata_q, readdata_d;

    // Decoded bus strobes and per-channel events
    logic                     wrEn;
    logic [1:0]               regOffset;
    logic [CH_BITS-1:0]       chAddr;
    logic [NUM_CH-1:0]        wrStatus, wrControl, wrPeriod, wrSnap, globalClr;
    logic [NUM_CH-1:0]        tick, timeout;
    logic                     unusedWriteData;

    assign wrEn      = chipselect & ~write_n;
    assign regOffset = address[1:0];
    assign chAddr    = address[ADDR_WIDTH-1:2];

    // Only some writedata bits matter for some parameterisations.
    assign unusedWriteData = ^writedata;

    // Address decode and tick generation. A tick is when the prescale count
    // has reached PRESCALE; a timeout is a tick seen with the counter at zero.
    always_comb begin
        wrStatus  = '0;
        wrControl = '0;
        wrPeriod  = '0;
        wrSnap    = '0;
        globalClr = '0;
        tick      = '0;
        timeout   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wrEn && (chAddr == CH_BITS'(c))) begin
                wrStatus[c]  = (regOffset == 2'd0);
                wrControl[c] = (regOffset == 2'd1);
                wrPeriod[c]  = (regOffset == 2'd2);
                wrSnap[c]    = (regOffset == 2'd3);
            end
            globalClr[c] = wrEn && (address == GLOBAL_ADDR) && writedata[c];
            tick[c]      = run_q[c] && (pscCnt_q[c] == prescale_q[c]);
            timeout[c]   = tick[c] && (counter_q[c] == '0);
        end
    end

    // Next-state for every channel. Tick effects are applied first, then bus
    // writes override them: a PERIOD write forces a stopped reload, and START
    // is applied after STOP so it wins when both are set. A timeout sets TO
    // after any clear so the event is never lost.
    always_comb begin
        period_d   = period_q;
        counter_d  = counter_q;
        snap_d     = snap_q;
        prescale_d = prescale_q;
        pscCnt_d   = pscCnt_q;
        run_d      = run_q;
        to_d       = to_q;
        ito_d      = ito_q;
        cont_d     = cont_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (run_q[c]) begin
                pscCnt_d[c] = tick[c] ? 8'd0 : pscCnt_q[c] + 8'd1;
            end
            if (tick[c]) begin
                if (timeout[c]) begin
                    counter_d[c] = period_q[c];
                    if (!cont_q[c]) begin
                        run_d[c] = 1'b0;
                    end
                end else begin
                    counter_d[c] = counter_q[c] - CNT_ONE;
                end
            end
            if (wrControl[c]) begin
                ito_d[c]      = writedata[0];
                cont_d[c]     = writedata[1];
                prescale_d[c] = writedata[15:8];
                if (writedata[3]) begin
                    run_d[c] = 1'b0;
                end
                if (writedata[2]) begin
                    run_d[c]    = 1'b1;
                    pscCnt_d[c] = 8'd0;
                end
            end
            if (wrPeriod[c]) begin
                period_d[c]  = writedata[COUNTER_WIDTH-1:0];
                counter_d[c] = writedata[COUNTER_WIDTH-1:0];
                run_d[c]     = 1'b0;
                pscCnt_d[c]  = 8'd0;
            end
            if (wrSnap[c]) begin
                snap_d[c] = counter_q[c];
            end
            if (wrStatus[c] || globalClr[c]) begin
                to_d[c] = 1'b0;
            end
            if (timeout[c]) begin
                to_d[c] = 1'b1;
            end
        end
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chAddr == CH_BITS'(c)) begin
                case (regOffset)
                    2'd0:    readdata_d = {30'd0, run_q[c], to_q[c]};
                    2'd1:    readdata_d = {16'd0, prescale_q[c], 6'd0, cont_q[c], ito_q[c]};
                    2'd2:    readdata_d = 32'(period_q[c]);
                    default: readdata_d = 32'(snap_q[c]);
                endcase
            end
        end
        if (address == GLOBAL_ADDR) begin
            readdata_d = 32'(to_q & ito_q);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c]   <= RESET_CNT;
                counter_q[c]  <= RESET_CNT;
                snap_q[c]     <= '0;
                prescale_q[c] <= 8'd0;
                pscCnt_q[c]   <= 8'd0;
            end
            run_q      <= '0;
            to_q       <= '0;
            ito_q      <= '0;
            cont_q     <= '0;
            readdata_q <= '0;
        end else begin
            period_q   <= period_d;
            counter_q  <= counter_d;
            snap_q     <= snap_d;
            prescale_q <= prescale_d;
            pscCnt_q   <= pscCnt_d;
            run_q      <= run_d;
            to_q       <= to_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(to_q & ito_q);

endmodule

// File: tb/tb_nios_system_multi_timer.sv
// tb_nios_system_multi_timer
// -----------------------------------------------------------------------------
// Testbench for nios_system_multi_timer. A table of bus reads/writes covers the
// reset state and register readback; hand-written sequences cover the timing
// of timeouts, prescaling, reloads, clears and reset. A second, narrow
// instance (16-bit counters, 2 channels) covers period truncation.
// -----------------------------------------------------------------------------
module tb_nios_system_multi_timer;

    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    logic [3:0]  address16 = '0;
    logic        chipselect16 = 1'b0;
    logic [31:0] readdata16;
    logic        irq16;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        doWrite;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    nios_system_multi_timer #(
        .NUM_CH(NUM_CH), .COUNTER_WIDTH(32), .RESET_PERIOD(99999), .ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    nios_system_multi_timer #(
        .NUM_CH(2), .COUNTER_WIDTH(16), .RESET_PERIOD(99999), .ADDR_WIDTH(4)
    ) dut16 (
        .clk(clk), .reset_n(reset_n), .address(address16), .chipselect(chipselect16),
        .write_n(write_n), .writedata(writedata), .readdata(readdata16), .irq(irq16)
    );

    // Compare one value and keep the tallies
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Bus tasks are entered at a negedge; the access lands on the next posedge
    task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic busRead(input logic [4:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] rd);
        rd = '0;
        if (v.doWrite) begin
            busWrite(v.addr, v.data);
        end else begin
            busRead(v.addr, rd);
        end
    endtask

    task automatic readCheck(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        busRead(a, rd);
        checkOutput(name, rd, exp);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        // Reset state table, then a few writes with readback on channel 3
        for (int c = 0; c < NUM_CH; c++) begin
            vecs.push_back('{1'b0, 5'(4*c + 0), 32'd0, 32'd0});
            vecs.push_back('{1'b0, 5'(4*c + 1), 32'd0, 32'd0});
            vecs.push_back('{1'b0, 5'(4*c + 2), 32'd0, 32'd99999});
            vecs.push_back('{1'b0, 5'(4*c + 3), 32'd0, 32'd0});
        end
        vecs.push_back('{1'b0, 5'd16, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 5'd17, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 5'd31, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 5'd13, 32'hFFFF_AB0B, 32'd0});
        vecs.push_back('{1'b0, 5'd13, 32'd0, 32'h0000_AB03});
        vecs.push_back('{1'b0, 5'd12, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 5'd13, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 5'd13, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 5'd14, 32'h1234_5678, 32'd0});
        vecs.push_back('{1'b0, 5'd14, 32'd0, 32'h1234_5678});
        vecs.push_back('{1'b1, 5'd15, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 5'd15, 32'd0, 32'h1234_5678});
        vecs.push_back('{1'b1, 5'd17, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{1'b0, 5'd17, 32'd0, 32'd0});

        repeat (3) @(negedge clk);
        checkOutput("reset readdata", readdata, 32'd0);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], rd);
            if (!vecs[i].doWrite) begin
                checkOutput($sformatf("vec%0d addr%0d", i, vecs[i].addr), rd, vecs[i].expected);
            end
        end

        // Narrow instance: reset period truncated, upper period bits dropped
        address16 = 4'd2;
        @(negedge clk);
        checkOutput("w16 reset period", readdata16, 32'h0000_869F);
        writedata    = 32'hFFFF_FFFF;
        chipselect16 = 1'b1;
        write_n      = 1'b0;
        @(negedge clk);
        chipselect16 = 1'b0;
        write_n      = 1'b1;
        @(negedge clk);
        checkOutput("w16 period trunc", readdata16, 32'h0000_FFFF);

        // Ch0: period 9, continuous with interrupt, timeouts every 10 cycles
        busWrite(5'd2, 32'd9);
        busWrite(5'd1, 32'h07);
        waitCycles(9);
        checkOutput("ch0 before timeout", {31'd0, irq}, 32'd0);
        waitCycles(1);
        checkOutput("ch0 first timeout", {31'd0, irq}, 32'd1);
        busWrite(5'd0, 32'd0);
        checkOutput("ch0 status clear", {31'd0, irq}, 32'd0);
        waitCycles(8);
        checkOutput("ch0 before 2nd timeout", {31'd0, irq}, 32'd0);
        busWrite(5'd0, 32'd0);
        checkOutput("ch0 clear loses to timeout", {31'd0, irq}, 32'd1);
        busWrite(5'd1, 32'h02);
        checkOutput("ch0 ito off", {31'd0, irq}, 32'd0);
        readCheck("ch0 status run+to", 5'd0, 32'h3);

        // Ch1: period 3, one-shot, prescale 4 -> timeout after 20 cycles
        busWrite(5'd6, 32'd3);
        busWrite(5'd5, 32'h0405);
        waitCycles(9);
        busWrite(5'd7, 32'd0);
        readCheck("ch1 snap pre-decrement", 5'd7, 32'd2);
        waitCycles(8);
        checkOutput("ch1 before timeout", {31'd0, irq}, 32'd0);
        waitCycles(1);
        checkOutput("ch1 timeout", {31'd0, irq}, 32'd1);
        readCheck("ch1 status one-shot", 5'd4, 32'h1);
        busWrite(5'd7, 32'd0);
        readCheck("ch1 snap reloaded", 5'd7, 32'd3);
        busWrite(5'd4, 32'd0);
        checkOutput("ch1 cleared", {31'd0, irq}, 32'd0);

        // Ch2: period write while running forces a stopped reload
        busWrite(5'd10, 32'd1000);
        busWrite(5'd9, 32'h04);
        waitCycles(5);
        busWrite(5'd10, 32'd50);
        busWrite(5'd11, 32'd0);
        readCheck("ch2 stopped after period", 5'd8, 32'h0);
        readCheck("ch2 snap after period", 5'd11, 32'd50);
        busWrite(5'd10, 32'd50);
        busWrite(5'd9, 32'h05);
        waitCycles(50);
        checkOutput("ch2 before timeout", {31'd0, irq}, 32'd0);
        waitCycles(1);
        checkOutput("ch2 timeout", {31'd0, irq}, 32'd1);
        readCheck("global ch2 pending", 5'd16, 32'h4);
        busWrite(5'd16, 32'h4);
        checkOutput("ch2 global clear", {31'd0, irq}, 32'd0);

        // Ch3 with interrupt, ch0 timing out without interrupt
        busWrite(5'd14, 32'd2);
        busWrite(5'd13, 32'h05);
        waitCycles(5);
        checkOutput("ch3 irq", {31'd0, irq}, 32'd1);
        readCheck("global ch3 only", 5'd16, 32'h8);
        busWrite(5'd16, 32'h8);
        checkOutput("ch3 global clear", {31'd0, irq}, 32'd0);
        readCheck("ch0 to kept", 5'd0, 32'h3);

        // START and STOP together; unmapped address
        busWrite(5'd13, 32'h0C);
        readCheck("ch3 start wins", 5'd12, 32'h2);
        readCheck("ch3 control strobes", 5'd13, 32'h0);
        readCheck("unmapped 17", 5'd17, 32'h0);

        // Ch2: period 0 continuous times out every cycle
        busWrite(5'd10, 32'd0);
        busWrite(5'd9, 32'h07);
        waitCycles(2);
        checkOutput("ch2 period0 irq", {31'd0, irq}, 32'd1);
        busWrite(5'd8, 32'd0);
        checkOutput("ch2 period0 clear lost", {31'd0, irq}, 32'd1);
        readCheck("ch2 period0 status", 5'd8, 32'h3);

        // Reset in the middle of counting
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid reset irq", {31'd0, irq}, 32'd0);
        checkOutput("mid reset readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        readCheck("post reset ch2 status", 5'd8, 32'h0);
        readCheck("post reset ch2 period", 5'd10, 32'd99999);
        readCheck("post reset ch0 status", 5'd0, 32'h0);
        readCheck("post reset global", 5'd16, 32'h0);
        waitCycles(3);
        checkOutput("post reset idle irq", {31'd0, irq}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
